// File: rtl/othello_pkg.sv
// Shared Othello board definitions: geometry, direction
// indices, per-direction address steps and scheduler states.
package othello_pkg;

    localparam int BOARD_DIM = 8;
    localparam int ADDR_W    = 7;

    typedef enum logic [2:0] {
        DIR_N  = 3'd0,
        DIR_NE = 3'd1,
        DIR_E  = 3'd2,
        DIR_SE = 3'd3,
        DIR_S  = 3'd4,
        DIR_SW = 3'd5,
        DIR_W  = 3'd6,
        DIR_NW = 3'd7
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Address increment for one step; negatives wrap mod 128.
    function automatic logic [ADDR_W-1:0] dir_step(
        input logic [2:0] dir
    );
        logic [ADDR_W-1:0] s;
        s = '0;
        unique case (dir_e'(dir))
            DIR_N:  s = 7'h78;
            DIR_NE: s = 7'h79;
            DIR_E:  s = 7'h01;
            DIR_SE: s = 7'h09;
            DIR_S:  s = 7'h08;
            DIR_SW: s = 7'h07;
            DIR_W:  s = 7'h7F;
            DIR_NW: s = 7'h77;
        endcase
        return s;
    endfunction

    function automatic logic [2:0] min3(
        input logic [2:0] a,
        input logic [2:0] b
    );
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/edge_limit_calc.sv
// Number of cells between a board cell and the edge of the
// board when walking in one of the eight directions.
module edge_limit_calc
    import othello_pkg::*;
(
    input  logic [2:0] row_i,
    input  logic [2:0] col_i,
    input  logic [2:0] dir_i,
    output logic [2:0] limit_o
);

    localparam logic [2:0] MAX_IDX = 3'(BOARD_DIM - 1);

    logic [2:0] up;
    logic [2:0] down;
    logic [2:0] left;
    logic [2:0] right;

    assign up    = row_i;
    assign down  = MAX_IDX - row_i;
    assign left  = col_i;
    assign right = MAX_IDX - col_i;

    // Diagonals are bounded by the nearer of their two edges.
    always_comb begin
        limit_o = 3'd0;
        unique case (dir_e'(dir_i))
            DIR_N:  limit_o = up;
            DIR_NE: limit_o = min3(up, right);
            DIR_E:  limit_o = right;
            DIR_SE: limit_o = min3(down, right);
            DIR_S:  limit_o = down;
            DIR_SW: limit_o = min3(down, left);
            DIR_W:  limit_o = left;
            DIR_NW: limit_o = min3(up, left);
        endcase
    end

endmodule

// File: rtl/move_dir_scheduler.sv
// Walks the 8 directions around a candidate cell, drives the
// single-direction checker for each and gathers a legality mask.
module move_dir_scheduler
    import othello_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 32,
    parameter bit EARLY_EXIT     = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic [2:0]        cell_row_i,
    input  logic [2:0]        cell_col_i,
    input  logic              player_i,
    output logic              chk_ld_o,
    output logic              chk_start_o,
    output logic [ADDR_W-1:0] chk_addr_o,
    output logic [ADDR_W-1:0] chk_step_o,
    output logic [2:0]        chk_limit_o,
    output logic              chk_player_o,
    input  logic              chk_done_i,
    input  logic              chk_dir_ok_i,
    output logic              mem_sel_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              legal_o,
    output logic [7:0]        dir_mask_o,
    output logic              timeout_o
);

    localparam int WD_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST =
        WD_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    state_e            state_d;
    logic [2:0]        dir_q;
    logic [2:0]        dir_d;
    logic [2:0]        row_q;
    logic [2:0]        row_d;
    logic [2:0]        col_q;
    logic [2:0]        col_d;
    logic              player_q;
    logic              player_d;
    logic [7:0]        mask_q;
    logic [7:0]        mask_d;
    logic              timeout_q;
    logic              timeout_d;
    logic [WD_W-1:0]   wd_q;
    logic [WD_W-1:0]   wd_d;

    logic [2:0]        limit;
    logic              skip;
    logic              scan_end;
    logic              wd_expired;
    logic              active;

    edge_limit_calc u_limit (
        .row_i   (row_q),
        .col_i   (col_q),
        .dir_i   (dir_q),
        .limit_o (limit)
    );

    // Fewer than two cells cannot hold an opponent run plus
    // a closing own piece, so such directions are not checked.
    assign skip       = (limit < 3'd2);
    assign wd_expired = (wd_q == WD_LAST);
    assign scan_end   = (dir_q == 3'd7) ||
                        (EARLY_EXIT && (mask_q != 8'd0));
    assign active     = (state_q != ST_IDLE);

    // State and datapath registers; reset aborts any scan.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= 3'd0;
            row_q     <= 3'd0;
            col_q     <= 3'd0;
            player_q  <= 1'b0;
            mask_q    <= 8'd0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            row_q     <= row_d;
            col_q     <= col_d;
            player_q  <= player_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
        end
    end

    // Next-state logic of the direction sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (start_i) state_d = ST_LOAD;
            ST_LOAD:
                state_d = skip ? ST_NEXT : ST_START;
            ST_START:
                state_d = ST_WAIT;
            ST_WAIT:
                if (chk_done_i || wd_expired)
                    state_d = ST_NEXT;
            ST_NEXT:
                state_d = scan_end ? ST_DONE : ST_LOAD;
            ST_DONE:
                state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    // Capture, mask collection, watchdog and direction index.
    always_comb begin
        dir_d     = dir_q;
        row_d     = row_q;
        col_d     = col_q;
        player_d  = player_q;
        mask_d    = mask_q;
        timeout_d = timeout_q;
        wd_d      = wd_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    row_d     = cell_row_i;
                    col_d     = cell_col_i;
                    player_d  = player_i;
                    mask_d    = 8'd0;
                    timeout_d = 1'b0;
                    dir_d     = 3'd0;
                end
            end
            ST_START: wd_d = '0;
            ST_WAIT: begin
                // A result arriving with the timeout still counts.
                if (chk_done_i) begin
                    mask_d[dir_q] = chk_dir_ok_i;
                end else if (wd_expired) begin
                    mask_d[dir_q] = 1'b0;
                    timeout_d     = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_NEXT:
                if (!scan_end) dir_d = dir_q + 3'd1;
            default: ;
        endcase
    end

    // Checker handshake, memory ownership and status outputs.
    always_comb begin
        chk_ld_o     = 1'b0;
        chk_start_o  = 1'b0;
        mem_sel_o    = 1'b0;
        done_o       = 1'b0;
        busy_o       = active;
        chk_addr_o   = '0;
        chk_step_o   = '0;
        chk_limit_o  = 3'd0;
        chk_player_o = 1'b0;
        unique case (state_q)
            ST_LOAD:  chk_ld_o = !skip;
            ST_START: begin
                chk_start_o = 1'b1;
                mem_sel_o   = 1'b1;
            end
            ST_WAIT:  mem_sel_o = 1'b1;
            ST_DONE:  done_o = 1'b1;
            default: ;
        endcase
        if (active) begin
            chk_addr_o   = {1'b0, row_q, col_q};
            chk_step_o   = dir_step(dir_q);
            chk_limit_o  = limit;
            chk_player_o = player_q;
        end
        legal_o    = |mask_q;
        dir_mask_o = mask_q;
        timeout_o  = timeout_q;
    end

endmodule

// File: tb/tb_move_dir_scheduler.sv
// Bench for move_dir_scheduler: two instances (default and
// short-timeout early-exit) driven by a mock line checker.
module tb_move_dir_scheduler;

    localparam int TO_A = 32;
    localparam int TO_B = 4;
    localparam int NV   = 10;

    int checks   = 0;
    int failures = 0;

    logic       clk = 1'b0;
    logic       rst     [2];
    logic       start_i [2];
    logic [2:0] row_i   [2];
    logic [2:0] col_i   [2];
    logic       ply_i   [2];
    logic       done_i  [2];
    logic       ok_i    [2];
    logic       ld_o    [2];
    logic       st_o    [2];
    logic [6:0] addr_o  [2];
    logic [6:0] step_o  [2];
    logic [2:0] limit_o [2];
    logic       cply_o  [2];
    logic       msel_o  [2];
    logic       busy_o  [2];
    logic       done_o  [2];
    logic       legal_o [2];
    logic [7:0] mask_o  [2];
    logic       to_o    [2];

    int         lat_cfg [8];
    logic [7:0] ok_cfg;
    int         wobs [8];
    logic [6:0] steps_obs [8];

    int dr [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};
    int dc [8] = '{0, 1, 1, 1, 0, -1, -1, -1};

    typedef struct {
        int         k;
        int         r;
        int         c;
        bit         p;
        logic [7:0] ok;
        logic [7:0] nev;
        int         lat;
        logic [7:0] est;
        logic [7:0] em;
        bit         eto;
        int         wd;
        int         wexp;
    } vec_t;

    vec_t tbl [NV];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        move_dir_scheduler #(
            .TIMEOUT_CYCLES (g == 0 ? TO_A : TO_B),
            .EARLY_EXIT     (g == 0 ? 1'b0 : 1'b1)
        ) u_dut (
            .clock        (clk),
            .reset        (rst[g]),
            .start_i      (start_i[g]),
            .cell_row_i   (row_i[g]),
            .cell_col_i   (col_i[g]),
            .player_i     (ply_i[g]),
            .chk_ld_o     (ld_o[g]),
            .chk_start_o  (st_o[g]),
            .chk_addr_o   (addr_o[g]),
            .chk_step_o   (step_o[g]),
            .chk_limit_o  (limit_o[g]),
            .chk_player_o (cply_o[g]),
            .chk_done_i   (done_i[g]),
            .chk_dir_ok_i (ok_i[g]),
            .mem_sel_o    (msel_o[g]),
            .busy_o       (busy_o[g]),
            .done_o       (done_o[g]),
            .legal_o      (legal_o[g]),
            .dir_mask_o   (mask_o[g]),
            .timeout_o    (to_o[g])
        );
    end

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Cells reachable before leaving the board.
    function automatic int walk_limit(int r, int c, int d);
        int n  = 0;
        int rr = r + dr[d];
        int cc = c + dc[d];
        while (rr >= 0 && rr < 8 && cc >= 0 && cc < 8) begin
            n++;
            rr += dr[d];
            cc += dc[d];
        end
        return n;
    endfunction

    function automatic logic [6:0] ref_step(int d);
        int s = dr[d] * 8 + dc[d];
        return 7'(s);
    endfunction

    function automatic int step2dir(input logic [6:0] s);
        for (int d = 0; d < 8; d++)
            if (ref_step(d) == s) return d;
        return -1;
    endfunction

    task automatic set_cfg(input logic [7:0] ok,
                           input logic [7:0] nev,
                           input int lat);
        for (int d = 0; d < 8; d++)
            lat_cfg[d] = nev[d] ? 0 : lat;
        ok_cfg = ok;
    endtask

    // Expected outcome of a whole scan from the board rules.
    task automatic model(input int k, input int r, input int c,
                         output logic [7:0] st,
                         output logic [7:0] m,
                         output bit to, output int busy);
        int T   = (k == 0) ? TO_A : TO_B;
        bit ee  = (k == 1);
        st = '0;
        m  = '0;
        to = 1'b0;
        busy = 1;
        for (int d = 0; d < 8; d++) begin
            int w;
            if (walk_limit(r, c, d) < 2) begin
                busy += 2;
            end else begin
                st[d] = 1'b1;
                if (lat_cfg[d] == 0 || lat_cfg[d] > T) begin
                    w  = T;
                    to = 1'b1;
                end else begin
                    w    = lat_cfg[d];
                    m[d] = ok_cfg[d];
                end
                busy += 3 + w;
            end
            if (ee && m != 0) break;
        end
    endtask

    task automatic run_scan(input int k, input int r, input int c,
                            input bit p, input bit noise,
                            input int abort_at,
                            input logic [7:0] exp_st,
                            input logic [7:0] exp_m,
                            input bit exp_to);
        logic [7:0] m_st;
        logic [7:0] m_m;
        bit         m_to;
        int         m_busy;
        logic [7:0] started = '0;
        int  n_ld = 0;
        int  n_done = 0;
        int  n_busy = 0;
        int  cyc = 0;
        int  cur = -1;
        bit  prev_ld = 1'b0;
        bit  aborted = 1'b0;
        bit  fin = 1'b0;
        bit  in_wait;
        model(k, r, c, m_st, m_m, m_to, m_busy);
        for (int d = 0; d < 8; d++) wobs[d] = 0;
        row_i[k]   = 3'(r);
        col_i[k]   = 3'(c);
        ply_i[k]   = p;
        start_i[k] = 1'b1;
        @(negedge clk);
        start_i[k] = 1'b0;
        while (!fin && cyc < 2000) begin
            if (busy_o[k]) n_busy++;
            if (done_o[k]) n_done++;
            if (st_o[k]) check("start_after_ld", 32'(prev_ld), 1);
            if (ld_o[k]) begin
                cur = step2dir(step_o[k]);
                n_ld++;
                check("ld_step_known", 32'(cur >= 0), 1);
                check("ld_msel", 32'(msel_o[k]), 0);
                check("ld_addr", 32'(addr_o[k]),
                      {25'd0, 1'b0, 3'(r), 3'(c)});
                check("ld_player", 32'(cply_o[k]), 32'(p));
                if (cur >= 0) begin
                    started[cur]   = 1'b1;
                    steps_obs[cur] = step_o[k];
                    check("ld_limit", 32'(limit_o[k]),
                          walk_limit(r, c, cur));
                end
            end
            prev_ld    = ld_o[k];
            in_wait    = msel_o[k] && !st_o[k];
            done_i[k]  = 1'b0;
            ok_i[k]    = noise ? 1'($urandom) : 1'b0;
            start_i[k] = 1'b0;
            if (!busy_o[k]) fin = 1'b1;
            if (!fin && in_wait && cur >= 0) begin
                wobs[cur]++;
                if (abort_at > 0 && n_ld == abort_at &&
                    wobs[cur] == 2) begin
                    check("pre_reset_mask", 32'(mask_o[k]),
                          32'(exp_m));
                    rst[k] = 1'b1;
                    #1;
                    check("rst_msel", 32'(msel_o[k]), 0);
                    check("rst_busy", 32'(busy_o[k]), 0);
                    check("rst_mask", 32'(mask_o[k]), 0);
                    aborted = 1'b1;
                    fin     = 1'b1;
                end else if (lat_cfg[cur] != 0 &&
                             wobs[cur] == lat_cfg[cur]) begin
                    done_i[k] = 1'b1;
                    ok_i[k]   = ok_cfg[cur];
                end
            end else if (!fin && noise) begin
                done_i[k] = ($urandom_range(0, 3) == 0);
                ok_i[k]   = 1'b1;
            end
            if (!fin && noise && $urandom_range(0, 3) == 0) begin
                start_i[k] = 1'b1;
                row_i[k]   = 3'($urandom);
                col_i[k]   = 3'($urandom);
            end
            if (!fin) begin
                @(negedge clk);
                cyc++;
            end
        end
        done_i[k]  = 1'b0;
        ok_i[k]    = 1'b0;
        start_i[k] = 1'b0;
        check("scan_bounded", 32'(fin), 1);
        if (aborted) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (done_o[k]) n_done++;
            end
            check("rst_no_done", n_done, 0);
            rst[k] = 1'b0;
            @(negedge clk);
        end else begin
            check("done_pulses", n_done, 1);
            check("busy_cycles", n_busy, m_busy);
            check("started_dirs", 32'(started), 32'(exp_st));
            check("ld_count", n_ld, $countones(exp_st));
            check("dir_mask", 32'(mask_o[k]), 32'(exp_m));
            check("legal", 32'(legal_o[k]), 32'(exp_m != 0));
            check("timeout", 32'(to_o[k]), 32'(exp_to));
            @(negedge clk);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit");
        $fatal(1, "time limit");
    end

    initial begin
        logic [7:0] est;
        logic [7:0] em;
        bit         eto;
        int         mb;
        int         k;
        int         r;
        int         c;
        int         T;

        for (int i = 0; i < 2; i++) begin
            rst[i]     = 1'b1;
            start_i[i] = 1'b0;
            row_i[i]   = 3'd0;
            col_i[i]   = 3'd0;
            ply_i[i]   = 1'b0;
            done_i[i]  = 1'b0;
            ok_i[i]    = 1'b0;
        end
        //        k r c p  ok     nev    lat est    em     to wd wexp
        tbl[0] = '{0,0,0,1,8'h08,8'h00,2, 8'h1C,8'h08,0,-1,0};
        tbl[1] = '{0,3,3,0,8'h00,8'h00,4, 8'hFF,8'h00,0,-1,0};
        tbl[2] = '{1,3,3,1,8'h10,8'h04,3, 8'h1F,8'h10,1, 2,4};
        tbl[3] = '{1,7,7,0,8'h80,8'h00,2, 8'hC1,8'h80,0,-1,0};
        tbl[4] = '{1,3,3,0,8'h02,8'h00,1, 8'h03,8'h02,0,-1,0};
        tbl[5] = '{0,3,3,1,8'h55,8'h00,1, 8'hFF,8'h55,0,-1,0};
        tbl[6] = '{0,1,6,0,8'hFF,8'h00,3, 8'h70,8'h70,0,-1,0};
        tbl[7] = '{1,3,3,1,8'hFF,8'h00,4, 8'h01,8'h01,0, 0,4};
        tbl[8] = '{0,0,0,0,8'h1C,8'h00,32,8'h1C,8'h1C,0, 3,32};
        tbl[9] = '{0,5,2,1,8'h00,8'hFF,1, 8'hFF,8'h00,1, 0,32};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_ctrl",
                  32'({ld_o[i], st_o[i], msel_o[i], busy_o[i],
                       done_o[i], legal_o[i], to_o[i]}), 0);
            check("reset_data",
                  32'({addr_o[i], step_o[i], limit_o[i],
                       cply_o[i], mask_o[i]}), 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            set_cfg(tbl[i].ok, tbl[i].nev, tbl[i].lat);
            run_scan(tbl[i].k, tbl[i].r, tbl[i].c, tbl[i].p,
                     1'b0, 0, tbl[i].est, tbl[i].em, tbl[i].eto);
            if (tbl[i].wd >= 0)
                check($sformatf("wait_cycles_v%0d", i),
                      wobs[tbl[i].wd], tbl[i].wexp);
        end

        // Checker answers while idle must leave the result alone.
        for (int i = 0; i < 3; i++) begin
            done_i[0] = 1'b1;
            ok_i[0]   = 1'b1;
            @(negedge clk);
        end
        done_i[0] = 1'b0;
        ok_i[0]   = 1'b0;
        @(negedge clk);
        check("idle_done_mask", 32'(mask_o[0]), 32'h00);
        check("idle_done_to", 32'(to_o[0]), 1);
        check("idle_done_busy", 32'(busy_o[0]), 0);

        // Exact wrapped step encodings.
        set_cfg(8'h00, 8'h00, 2);
        run_scan(0, 3, 3, 1'b0, 1'b0, 0, 8'hFF, 8'h00, 1'b0);
        check("step_w", 32'(steps_obs[6]), 32'h7F);
        check("step_nw", 32'(steps_obs[7]), 32'h77);
        check("step_ne", 32'(steps_obs[1]), 32'h79);

        // Reset in the middle of the second direction's wait.
        set_cfg(8'h01, 8'hFE, 1);
        run_scan(0, 3, 3, 1'b1, 1'b0, 2, 8'h00, 8'h01, 1'b0);
        set_cfg(8'h24, 8'h00, 2);
        run_scan(0, 3, 3, 1'b0, 1'b0, 0, 8'hFF, 8'h24, 1'b0);

        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 1);
            r = $urandom_range(0, 7);
            c = $urandom_range(0, 7);
            T = (k == 0) ? TO_A : TO_B;
            for (int d = 0; d < 8; d++) begin
                case ($urandom_range(0, 7))
                    0:       lat_cfg[d] = 0;
                    1:       lat_cfg[d] = 1;
                    2:       lat_cfg[d] = 2;
                    3:       lat_cfg[d] = 3;
                    4:       lat_cfg[d] = T - 1;
                    5:       lat_cfg[d] = T;
                    6:       lat_cfg[d] = T + 1;
                    default: lat_cfg[d] = 2;
                endcase
            end
            ok_cfg = 8'($urandom);
            model(k, r, c, est, em, eto, mb);
            run_scan(k, r, c, 1'($urandom), 1'b1, 0,
                     est, em, eto);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
